// File: rtl/divider32_if.sv
`default_nettype none
// ============================================================================
//  Module      : divider32_if
//  Description : Request/response bundle for the 32-bit iterative divider.
//                master : drives start_in, op_in, dividend_in, divisor_in;
//                         observes busy_out, done_out, result_out.
//                slave  : the divider itself (mirror image of master).
//  Signals     : start_in     1   request, honoured only when divider is idle
//                op_in        2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//                dividend_in  32  dividend, captured with start_in
//                divisor_in   32  divisor, captured with start_in
//                busy_out     1   high while iterating
//                done_out     1   one-cycle pulse, result_out valid
//                result_out   32  quotient or remainder
//  Revision    : 1.0 - initial release
// ============================================================================
interface divider32_if;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] result_out;

  modport master (
    output start_in, op_in, dividend_in, divisor_in,
    input  busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, op_in, dividend_in, divisor_in,
    output busy_out, done_out, result_out
  );
endinterface
`default_nettype wire

// File: rtl/divider32.sv
`default_nettype none
// ============================================================================
//  Module      : divider32
//  Description : RV32M-compatible 32-bit divider (DIV/DIVU/REM/REMU) using a
//                restoring algorithm, one quotient bit per clock, MSB first.
//                Divide-by-zero and signed overflow complete immediately.
//  Ports       : clk_in    1   clock, rising edge
//                rst_n_in  1   synchronous reset, active-low
//                bus           divider32_if.slave (request/response bundle)
//  Revision    : 1.0 - initial release
// ============================================================================
module divider32 (
  input  logic        clk_in,
  input  logic        rst_n_in,
  divider32_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Operation context captured at start
  logic        rem_sel_q;   // 1: remainder is the result
  logic        neg_q;       // 1: negate the selected result
  logic [31:0] dvd_q;       // dividend magnitude, shifts out MSB-first; fills with quotient
  logic [31:0] dvs_q;       // divisor magnitude
  logic [31:0] rem_q;       // partial remainder
  logic [4:0]  cnt_q;
  logic [31:0] result_q;

  // Request decode
  logic        signed_op;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        overflow;

  // One restoring step
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        qbit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  logic        busy;
  logic        done;

  always_comb begin
    signed_op = ~bus.op_in[0];
    sign_a    = signed_op & bus.dividend_in[31];
    sign_b    = signed_op & bus.divisor_in[31];
    mag_a     = sign_a ? (~bus.dividend_in + 32'd1) : bus.dividend_in;
    mag_b     = sign_b ? (~bus.divisor_in + 32'd1) : bus.divisor_in;
    div_zero  = (bus.divisor_in == 32'd0);
    overflow  = signed_op && (bus.dividend_in == 32'h8000_0000) &&
                (bus.divisor_in == 32'hFFFF_FFFF);
  end

  // Because rem_q < dvs_q is invariant, a 33-bit difference is enough: its
  // top bit is a true sign bit and, when clear, the low 32 bits hold the
  // new remainder.
  always_comb begin
    shifted   = {rem_q, dvd_q[31]};
    trial     = shifted - {1'b0, dvs_q};
    qbit      = ~trial[32];
    rem_next  = qbit ? trial[31:0] : shifted[31:0];
    quo_next  = {dvd_q[30:0], qbit};
    quo_fixed = neg_q ? (~quo_next + 32'd1) : quo_next;
    rem_fixed = neg_q ? (~rem_next + 32'd1) : rem_next;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = (div_zero || overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 5'd0;
      result_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            rem_sel_q <= bus.op_in[1];
            // REM takes the dividend's sign; DIV negates when signs differ
            neg_q     <= bus.op_in[1] ? sign_a : (sign_a ^ sign_b);
            dvd_q     <= mag_a;
            dvs_q     <= mag_b;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd31;
            if (div_zero) begin
              result_q <= bus.op_in[1] ? bus.dividend_in : 32'hFFFF_FFFF;
            end else if (overflow) begin
              result_q <= bus.op_in[1] ? 32'd0 : 32'h8000_0000;
            end
          end
        end
        CALC: begin
          dvd_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            result_q <= rem_sel_q ? rem_fixed : quo_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_out   = busy;
  assign bus.done_out   = done;
  assign bus.result_out = result_q;

endmodule
`default_nettype wire

// File: tb/tb_divider32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider32
//  Description : Self-checking bench for divider32: directed vector table
//                plus hand-written restart-ignore and mid-operation reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  divider32_if bus();

  divider32 dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;   // expected done cycle
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issue one request and watch 40 cycles. Operands are scrambled right after
  // E0 to show the in-flight operation is unaffected. If restart_at >= 0, a
  // second request is held on start_in from that cycle until cycle 33.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int restart_at,
                     output int done_cyc, output logic [31:0] res,
                     output int busy_cnt, output int pulses, output logic busy33);
    @(negedge clk);
    bus.start_in    = 1'b1;
    bus.op_in       = op;
    bus.dividend_in = a;
    bus.divisor_in  = b;
    @(posedge clk); #1;
    bus.start_in    = 1'b0;
    bus.op_in       = ~op;
    bus.dividend_in = ~a;
    bus.divisor_in  = b + 32'd1;
    done_cyc = -1;
    res      = 32'hDEAD_BEEF;
    busy_cnt = 0;
    pulses   = 0;
    busy33   = 1'bx;
    for (int c = 0; c < 40; c++) begin
      if (c == restart_at) begin
        bus.start_in    = 1'b1;
        bus.op_in       = OP_DIV;
        bus.dividend_in = 32'd1000;
        bus.divisor_in  = 32'd3;
      end
      if (c == 33) bus.start_in = 1'b0;
      if (bus.busy_out) busy_cnt++;
      if (c == 33) busy33 = bus.busy_out;
      if (bus.done_out) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res      = bus.result_out;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          dc, bc, pc;
    logic [31:0] r;
    logic        b33;

    passed = 0;
    total  = 0;

    //            op       dividend       divisor        expected       cyc
    vecs[0]  = '{OP_DIVU, 32'd100,       32'd7,         32'h0000_000E, 32};
    vecs[1]  = '{OP_REMU, 32'd100,       32'd7,         32'h0000_0002, 32};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
    vecs[4]  = '{OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32};
    vecs[5]  = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32};
    vecs[6]  = '{OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 0};
    vecs[7]  = '{OP_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678, 0};
    vecs[8]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[9]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32};
    vecs[11] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32};
    vecs[12] = '{OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32};
    vecs[13] = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32};
    vecs[14] = '{OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32};
    vecs[15] = '{OP_DIVU, 32'd3,         32'd5,         32'h0000_0000, 32};
    vecs[16] = '{OP_REMU, 32'd3,         32'd5,         32'h0000_0003, 32};
    vecs[17] = '{OP_DIV,  32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 32};
    vecs[18] = '{OP_REM,  32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 32};
    vecs[19] = '{OP_DIV,  32'd0,         32'd0,         32'hFFFF_FFFF, 0};

    bus.start_in    = 1'b1;   // reset must win over start
    bus.op_in       = OP_DIVU;
    bus.dividend_in = 32'd100;
    bus.divisor_in  = 32'd7;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'd0, bus.busy_out}, 32'd0);
    check("reset done",   {31'd0, bus.done_out}, 32'd0);
    check("reset result", bus.result_out,        32'd0);
    @(negedge clk);
    bus.start_in = 1'b0;
    rst_n        = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, -1, dc, r, bc, pc, b33);
      check($sformatf("vec%0d result", i),     r,          vecs[i].exp);
      check($sformatf("vec%0d done cycle", i), dc,         vecs[i].cyc);
      check($sformatf("vec%0d busy cycles", i), bc,        (vecs[i].cyc == 0) ? 0 : 32);
      check($sformatf("vec%0d done pulses", i), pc,        32'd1);
      check($sformatf("vec%0d result hold", i), bus.result_out, vecs[i].exp);
    end

    // Second request during CALC and DONE is ignored
    run(OP_DIVU, 32'd100, 32'd7, 5, dc, r, bc, pc, b33);
    check("restart result",      r,               32'h0000_000E);
    check("restart done cycle",  dc,              32'd32);
    check("restart done pulses", pc,              32'd1);
    check("restart busy c33",    {31'd0, b33},    32'd0);
    check("restart busy cycles", bc,              32'd32);

    // Reset at E10 aborts; new start at E12 completes normally
    @(negedge clk);
    bus.start_in    = 1'b1;
    bus.op_in       = OP_DIVU;
    bus.dividend_in = 32'd100;
    bus.divisor_in  = 32'd7;
    @(posedge clk); #1;       // cycle 0
    bus.start_in = 1'b0;
    pc = 0;
    for (int c = 0; c < 9; c++) begin
      if (bus.done_out) pc++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;             // sampled at E10
    @(posedge clk); #1;       // cycle 10
    check("abort busy c10",   {31'd0, bus.busy_out}, 32'd0);
    check("abort done c10",   {31'd0, bus.done_out}, 32'd0);
    check("abort result c10", bus.result_out,        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;       // cycle 11
    if (bus.done_out) pc++;
    check("abort no done", pc, 32'd0);
    check("abort busy c11", {31'd0, bus.busy_out}, 32'd0);
    run(OP_REMU, 32'd100, 32'd7, -1, dc, r, bc, pc, b33);
    check("post-reset result",     r,  32'h0000_0002);
    check("post-reset done cycle", dc, 32'd32);
    check("post-reset busy",       bc, 32'd32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
